solver_loader: RTL

Sequencer that drives the solver's limb-write port. It accepts one job per handshake, streams the job's c_re and c_im limbs out of the coordinate memory (1-cycle read latency), and presents them as single-cycle limb writes on wr_en/wr_sel/wr_limb/wr_data. After the last limb it pulses start. It sits between the host-side coordinate RAM and one solver instance.

---
 rtl/solver_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/solver_loader.sv
// Streams one job's c_re/c_im limbs from coordinate memory into the solver's limb-write port, then pulses start.
// Define SOLVER_LOADER_MSB_FIRST_EN to issue limbs in descending index order within each component.
module solver_loader #(
   parameter int LIMB_INDEX_BITS = 6,
   parameter int LIMB_SIZE_BITS  = 27,
   parameter int ADDR_BITS       = 10
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [ADDR_BITS-1:0]       job_base,
   input  logic [LIMB_INDEX_BITS-1:0] job_limbs_m1,
   input  logic                       solver_idle,
   output logic                       mem_rd_en,
   output logic [ADDR_BITS-1:0]       mem_rd_addr,
   input  logic [LIMB_SIZE_BITS-1:0]  mem_rd_data,
   output logic                       wr_en,
   output logic                       wr_sel,
   output logic [LIMB_INDEX_BITS-1:0] wr_limb,
   output logic [LIMB_SIZE_BITS-1:0]  wr_data,
   output logic                       start,
   output logic                       busy
);

   localparam int KW = LIMB_INDEX_BITS + 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_START} state_t;

   state_t                     state_reg;
   logic [ADDR_BITS-1:0]       base_reg;
   logic [LIMB_INDEX_BITS-1:0] limbs_m1_reg;
   logic [KW-1:0]              k_reg;
   logic                       rd_sel_reg;
   logic [LIMB_INDEX_BITS-1:0] rd_limb_reg;

   logic [KW-1:0]              n_ext;
   logic [KW-1:0]              k_next;
   logic [KW-1:0]              idx_wide;
   logic                       sel_next;
   logic [LIMB_INDEX_BITS-1:0] idx_next;
   logic [LIMB_INDEX_BITS-1:0] limb_next;
   logic [ADDR_BITS-1:0]       addr_next;
   logic                       last_read;

   // Address/limb of the read to issue on the next edge; k restarts at 0 when leaving WAIT.
   always_comb begin
      n_ext     = {1'b0, limbs_m1_reg} + KW'(1);
      k_next    = (state_reg == S_READ) ? k_reg + KW'(1) : '0;
      sel_next  = (k_next >= n_ext);
      idx_wide  = sel_next ? k_next - n_ext : k_next;
      idx_next  = idx_wide[LIMB_INDEX_BITS-1:0];
`ifdef SOLVER_LOADER_MSB_FIRST_EN
      limb_next = limbs_m1_reg - idx_next;
`else
      limb_next = idx_next;
`endif
      addr_next = base_reg + (sel_next ? ADDR_BITS'(n_ext) : '0) + ADDR_BITS'(limb_next);
      // 2N-1 == 2*m1+1
      last_read = (k_reg == {limbs_m1_reg, 1'b1});
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         base_reg     <= '0;
         limbs_m1_reg <= '0;
         k_reg        <= '0;
         rd_sel_reg   <= 1'b0;
         rd_limb_reg  <= '0;
         job_ready    <= 1'b0;
         busy         <= 1'b0;
         mem_rd_en    <= 1'b0;
         mem_rd_addr  <= '0;
         wr_en        <= 1'b0;
         wr_sel       <= 1'b0;
         wr_limb      <= '0;
         start        <= 1'b0;
      end else begin
         wr_en   <= mem_rd_en;
         wr_sel  <= rd_sel_reg;
         wr_limb <= rd_limb_reg;
         start   <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               job_ready <= 1'b1;
               if (job_valid && job_ready) begin
                  base_reg     <= job_base;
                  limbs_m1_reg <= job_limbs_m1;
                  job_ready    <= 1'b0;
                  busy         <= 1'b1;
                  state_reg    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (solver_idle) begin
                  k_reg       <= '0;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= addr_next;
                  rd_sel_reg  <= sel_next;
                  rd_limb_reg <= limb_next;
                  state_reg   <= S_READ;
               end
            end
            S_READ: begin
               if (last_read) begin
                  mem_rd_en <= 1'b0;
                  state_reg <= S_DRAIN;
               end else begin
                  k_reg       <= k_next;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= addr_next;
                  rd_sel_reg  <= sel_next;
                  rd_limb_reg <= limb_next;
               end
            end
            S_DRAIN: begin
               start     <= 1'b1;
               state_reg <= S_START;
            end
            S_START: begin
               busy      <= 1'b0;
               job_ready <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Memory data lines up with the delayed write strobe, so it passes straight through.
   assign wr_data = mem_rd_data;

endmodule
